// File: rtl/axis_frame_fifo_arb.sv
// Frame-granular round-robin arbiter feeding one shared AXI-stream frame FIFO.
// Oversize frames are cut at MAX_FRAME_BEATS and tagged bad so the FIFO drops them.
module axis_frame_fifo_arb #(
    parameter int S_COUNT         = 4,
    parameter int DATA_WIDTH      = 64,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int ID_WIDTH        = 8,
    parameter int DEST_WIDTH      = 8,
    parameter int USER_WIDTH      = 1,
    parameter int MAX_FRAME_BEATS = 256,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [ID_WIDTH-1:0]           m_axis_tid,
    output logic [DEST_WIDTH-1:0]         m_axis_tdest,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic                          grant_valid,
    output logic [$clog2(S_COUNT)-1:0]    grant_index,
    output logic [S_COUNT-1:0]            status_truncate
);

    localparam int IDX_W = $clog2(S_COUNT);
    localparam int CNT_W = $clog2(MAX_FRAME_BEATS + 1);

    typedef enum logic [1:0] {IDLE, PASS, DISCARD} state_t;

    state_t           state;
    logic [IDX_W-1:0] last_ptr;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] probe;
    logic             pick_found;
    logic [CNT_W-1:0] beat_cnt;

    logic                  sel_valid;
    logic                  sel_last;
    logic [USER_WIDTH-1:0] sel_user;
    logic                  limit_beat;
    logic                  trunc_beat;

    assign sel_valid  = s_axis_tvalid[grant_index];
    assign sel_last   = s_axis_tlast[grant_index];
    assign sel_user   = s_axis_tuser[grant_index*USER_WIDTH +: USER_WIDTH];
    assign limit_beat = (beat_cnt == CNT_W'(MAX_FRAME_BEATS - 1));
    assign trunc_beat = (state == PASS) && limit_beat && !sel_last;

    // Scan from the farthest offset down so the port nearest last_ptr+1 wins.
    always_comb begin
        pick       = '0;
        probe      = '0;
        pick_found = 1'b0;
        for (int i = S_COUNT; i >= 1; i--) begin
            probe = IDX_W'((int'(last_ptr) + i) % S_COUNT);
            if (s_axis_tvalid[probe]) begin
                pick       = probe;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = s_axis_tdata[grant_index*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep  = s_axis_tkeep[grant_index*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_tdest  = s_axis_tdest[grant_index*DEST_WIDTH +: DEST_WIDTH];
        m_axis_tlast  = sel_last | trunc_beat;
        m_axis_tuser  = trunc_beat ? USER_BAD_FRAME_VALUE : sel_user;
        m_axis_tid    = ID_WIDTH'(grant_index);
        case (state)
            PASS: begin
                s_axis_tready[grant_index] = m_axis_tready;
                m_axis_tvalid              = sel_valid;
            end
            DISCARD: begin
                s_axis_tready[grant_index] = 1'b1;
            end
            default: ;
        endcase
    end

    // A frame holds the grant until its tlast is consumed; truncation sinks the tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            grant_valid     <= 1'b0;
            grant_index     <= '0;
            last_ptr        <= IDX_W'(S_COUNT - 1);
            beat_cnt        <= '0;
            status_truncate <= '0;
        end else begin
            status_truncate <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_index <= pick;
                        last_ptr    <= pick;
                        grant_valid <= 1'b1;
                        beat_cnt    <= '0;
                        state       <= PASS;
                    end
                end
                PASS: begin
                    if (sel_valid && m_axis_tready) begin
                        if (sel_last) begin
                            beat_cnt    <= '0;
                            grant_valid <= 1'b0;
                            state       <= IDLE;
                        end else if (limit_beat) begin
                            beat_cnt                     <= '0;
                            status_truncate[grant_index] <= 1'b1;
                            state                        <= DISCARD;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                DISCARD: begin
                    if (sel_valid && sel_last) begin
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_fifo_arb.sv
// Bench for axis_frame_fifo_arb: per-port source queues, a frame-level scoreboard
// model checked every cycle, and literal expectations on grant order and counts.
module tb_axis_frame_fifo_arb;

    localparam int S    = 4;
    localparam int DW   = 64;
    localparam int KW   = 8;
    localparam int IW   = 8;
    localparam int DSW  = 8;
    localparam int UW   = 1;
    localparam int MAXB = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [S*DW-1:0]  s_axis_tdata;
    logic [S*KW-1:0]  s_axis_tkeep;
    logic [S-1:0]     s_axis_tvalid;
    logic [S-1:0]     s_axis_tready;
    logic [S-1:0]     s_axis_tlast;
    logic [S*DSW-1:0] s_axis_tdest;
    logic [S*UW-1:0]  s_axis_tuser;
    logic [DW-1:0]    m_axis_tdata;
    logic [KW-1:0]    m_axis_tkeep;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;
    logic [IW-1:0]    m_axis_tid;
    logic [DSW-1:0]   m_axis_tdest;
    logic [UW-1:0]    m_axis_tuser;
    logic             grant_valid;
    logic [1:0]       grant_index;
    logic [S-1:0]     status_truncate;

    always #5 clk = ~clk;

    axis_frame_fifo_arb #(
        .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW),
        .DEST_WIDTH(DSW), .USER_WIDTH(UW), .MAX_FRAME_BEATS(MAXB),
        .USER_BAD_FRAME_VALUE(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdest(s_axis_tdest),
        .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
        .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
        .grant_valid(grant_valid), .grant_index(grant_index),
        .status_truncate(status_truncate)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [7:0]  dest;
        logic        user;
    } beat_t;

    typedef struct packed {
        beat_t      b;
        logic [7:0] tid;
        logic       trunc;
    } exp_t;

    beat_t src_q     [S][$];
    beat_t model_src [S][$];
    exp_t  exp_q[$];
    int    grant_log[$];
    int    want[$];

    bit         model_busy;
    int         model_owner;
    int         model_last;
    logic [3:0] exp_trunc;
    logic [3:0] next_trunc;
    logic [3:0] exp_rdy;
    logic       exp_mvalid;

    int out_beats;
    int trunc_cycles;
    int hs_count [S];
    int frame_id;
    bit toggle_ready;
    int n_compared = 0;
    int n_mismatch = 0;

    beat_t c_beat;
    exp_t  c_exp;
    int    c_k;
    bit    c_done;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit anyPending();
        bit p = 1'b0;
        for (int n = 0; n < S; n++) if (src_q[n].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic driveInputs();
        for (int n = 0; n < S; n++) begin
            if (src_q[n].size() > 0) begin
                s_axis_tvalid[n]            = 1'b1;
                s_axis_tdata[n*DW +: DW]    = src_q[n][0].data;
                s_axis_tkeep[n*KW +: KW]    = src_q[n][0].keep;
                s_axis_tlast[n]             = src_q[n][0].last;
                s_axis_tdest[n*DSW +: DSW]  = src_q[n][0].dest;
                s_axis_tuser[n]             = src_q[n][0].user;
            end else begin
                s_axis_tvalid[n]            = 1'b0;
                s_axis_tdata[n*DW +: DW]    = '0;
                s_axis_tkeep[n*KW +: KW]    = '0;
                s_axis_tlast[n]             = 1'b0;
                s_axis_tdest[n*DSW +: DSW]  = '0;
                s_axis_tuser[n]             = 1'b0;
            end
        end
    endtask

    // Queue one frame of nbeats on a port, for both the driver and the model.
    task automatic applyStimulus(input int port, input int nbeats, input logic user);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.data = (64'(port) << 56) | (64'(frame_id) << 32) | 64'(i);
            b.keep = (i == nbeats - 1) ? 8'h0F : 8'hFF;
            b.last = (i == nbeats - 1);
            b.dest = 8'((port << 4) + (frame_id & 15));
            b.user = user;
            src_q[port].push_back(b);
            model_src[port].push_back(b);
        end
        frame_id++;
        driveInputs();
    endtask

    task automatic stepCycle();
        logic [S-1:0] hs;
        @(negedge clk);
        hs = s_axis_tvalid & s_axis_tready;
        @(posedge clk);
        #1;
        for (int n = 0; n < S; n++) begin
            if (hs[n] && src_q[n].size() > 0) begin
                void'(src_q[n].pop_front());
                hs_count[n]++;
            end
        end
        if (toggle_ready) m_axis_tready = ~m_axis_tready;
        driveInputs();
    endtask

    task automatic doReset();
        rst = 1'b1;
        for (int n = 0; n < S; n++) begin
            src_q[n].delete();
            model_src[n].delete();
            hs_count[n] = 0;
        end
        toggle_ready  = 1'b0;
        m_axis_tready = 1'b1;
        driveInputs();
        stepCycle();
        stepCycle();
        rst = 1'b0;
        out_beats    = 0;
        trunc_cycles = 0;
        grant_log.delete();
    endtask

    task automatic runUntilDone(input string name, input int budget);
        int c = 0;
        do begin
            stepCycle();
            c++;
        end while ((anyPending() || model_busy) && c < budget);
        if (c >= budget) checkOutput({name, "_timeout"}, 64'(c), 64'(budget - 1));
        stepCycle();
        stepCycle();
    endtask

    task automatic checkLog(input string name);
        checkOutput({name, "_grants"}, 64'(grant_log.size()), 64'(want.size()));
        for (int i = 0; i < want.size() && i < grant_log.size(); i++)
            checkOutput({name, "_tid_order"}, 64'(grant_log[i]), 64'(want[i]));
    endtask

    // Frame-level model: which port owns the output, which beats it must emit,
    // and when a truncation pulse is owed; compared against the DUT every cycle.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_s_tready", 64'(s_axis_tready), 64'(0));
            checkOutput("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
            checkOutput("rst_grant_valid", 64'(grant_valid), 64'(0));
            checkOutput("rst_grant_index", 64'(grant_index), 64'(0));
            checkOutput("rst_status_truncate", 64'(status_truncate), 64'(0));
            model_busy = 1'b0;
            model_last = S - 1;
            exp_trunc  = '0;
            exp_q.delete();
        end else begin
            exp_rdy    = '0;
            exp_mvalid = 1'b0;
            next_trunc = '0;
            if (model_busy) begin
                exp_rdy[model_owner] = (exp_q.size() > 0) ? m_axis_tready : 1'b1;
                exp_mvalid           = (exp_q.size() > 0) && s_axis_tvalid[model_owner];
            end
            checkOutput("grant_valid", 64'(grant_valid), 64'(model_busy));
            if (model_busy) checkOutput("grant_index", 64'(grant_index), 64'(model_owner));
            checkOutput("status_truncate", 64'(status_truncate), 64'(exp_trunc));
            checkOutput("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
            checkOutput("m_tvalid", 64'(m_axis_tvalid), 64'(exp_mvalid));
            if (status_truncate != '0) trunc_cycles++;

            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", 64'(1), 64'(0));
                end else begin
                    c_exp = exp_q.pop_front();
                    checkOutput("m_tdata", m_axis_tdata, c_exp.b.data);
                    checkOutput("m_tkeep", 64'(m_axis_tkeep), 64'(c_exp.b.keep));
                    checkOutput("m_tlast", 64'(m_axis_tlast), 64'(c_exp.b.last));
                    checkOutput("m_tid", 64'(m_axis_tid), 64'(c_exp.tid));
                    checkOutput("m_tdest", 64'(m_axis_tdest), 64'(c_exp.b.dest));
                    checkOutput("m_tuser", 64'(m_axis_tuser), 64'(c_exp.b.user));
                    out_beats++;
                    if (c_exp.trunc) next_trunc[model_owner] = 1'b1;
                end
            end
            exp_trunc = next_trunc;

            if (model_busy) begin
                if (s_axis_tvalid[model_owner] && s_axis_tready[model_owner] &&
                    s_axis_tlast[model_owner]) begin
                    model_busy = 1'b0;
                    if (exp_q.size() != 0) checkOutput("frame_beats_left", 64'(exp_q.size()), 64'(0));
                end
            end else if (s_axis_tvalid != '0) begin
                for (int i = S; i >= 1; i--)
                    if (s_axis_tvalid[(model_last + i) % S]) model_owner = (model_last + i) % S;
                model_last = model_owner;
                model_busy = 1'b1;
                grant_log.push_back(model_owner);
                c_k    = 0;
                c_done = 1'b0;
                while (!c_done && model_src[model_owner].size() > 0) begin
                    c_beat = model_src[model_owner].pop_front();
                    if (c_beat.last) c_done = 1'b1;
                    if (c_k < MAXB) begin
                        c_exp.b     = c_beat;
                        c_exp.tid   = 8'(model_owner);
                        c_exp.trunc = 1'b0;
                        if (c_k == MAXB - 1 && !c_beat.last) begin
                            c_exp.b.last = 1'b1;
                            c_exp.b.user = 1'b1;
                            c_exp.trunc  = 1'b1;
                        end
                        exp_q.push_back(c_exp);
                    end
                    c_k++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        frame_id      = 0;
        toggle_ready  = 1'b0;
        m_axis_tready = 1'b1;
        model_busy    = 1'b0;
        model_owner   = 0;
        model_last    = S - 1;
        exp_trunc     = '0;
        for (int n = 0; n < S; n++) hs_count[n] = 0;
        driveInputs();

        // Reset values visible after release with no traffic.
        doReset();
        checkOutput("post_rst_s_tready", 64'(s_axis_tready), 64'(0));
        checkOutput("post_rst_grant_valid", 64'(grant_valid), 64'(0));
        checkOutput("post_rst_grant_index", 64'(grant_index), 64'(0));
        checkOutput("post_rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));

        $display("[TB] all four ports, one 3-beat frame each");
        for (int p = 0; p < S; p++) applyStimulus(p, 3, 1'b0);
        runUntilDone("rr4", 200);
        want = '{0, 1, 2, 3};
        checkLog("rr4");
        checkOutput("rr4_out_beats", 64'(out_beats), 64'(12));
        checkOutput("rr4_trunc_cycles", 64'(trunc_cycles), 64'(0));

        $display("[TB] port 2, 5-beat frame at the beat limit, toggling m_axis_tready");
        doReset();
        toggle_ready = 1'b1;
        applyStimulus(2, 5, 1'b0);
        runUntilDone("toggle", 200);
        want = '{2};
        checkLog("toggle");
        checkOutput("toggle_out_beats", 64'(out_beats), 64'(5));
        checkOutput("toggle_trunc_cycles", 64'(trunc_cycles), 64'(0));

        $display("[TB] port 1, 7-beat frame truncated at 5 beats");
        doReset();
        applyStimulus(1, 7, 1'b0);
        runUntilDone("trunc", 200);
        want = '{1};
        checkLog("trunc");
        checkOutput("trunc_out_beats", 64'(out_beats), 64'(5));
        checkOutput("trunc_cycles", 64'(trunc_cycles), 64'(1));
        checkOutput("trunc_in_consumed", 64'(hs_count[1]), 64'(7));

        $display("[TB] reset in the middle of a port 3 frame");
        doReset();
        applyStimulus(3, 5, 1'b0);
        c = 0;
        while (hs_count[3] < 2 && c < 20) begin
            stepCycle();
            c++;
        end
        if (c >= 20) checkOutput("midrst_timeout", 64'(c), 64'(19));
        rst = 1'b1;
        #1;
        checkOutput("midrst_s_tready", 64'(s_axis_tready), 64'(0));
        checkOutput("midrst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        checkOutput("midrst_grant_valid", 64'(grant_valid), 64'(0));
        doReset();
        applyStimulus(0, 2, 1'b0);
        applyStimulus(3, 2, 1'b0);
        runUntilDone("midrst", 200);
        want = '{0, 3};
        checkLog("midrst");

        $display("[TB] ports 0 and 1, four 1-beat frames each");
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 1'b0);
            applyStimulus(1, 1, 1'b1);
        end
        runUntilDone("pair", 200);
        want = '{0, 1, 0, 1, 0, 1, 0, 1};
        checkLog("pair");
        checkOutput("pair_out_beats", 64'(out_beats), 64'(8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
